// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the convolution run scheduler.
// State encoding plus the fixed pooled-result geometry of the processor.
package conv_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_GO,
        S_RUN,
        S_NEXT
    } state_t;

    localparam int OUT_PER_RUN = 9;
    localparam int POOL_ADDR_W = 4;
    localparam int DATA_W      = 23;

endpackage

// File: rtl/run_result_tracker.sv
// Collects one run's pooled results: range check, seen mask,
// registered output-memory write port and all-seen flag.
module run_result_tracker #(
    parameter int DATA_W = 23,
    parameter int OUT_AW = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_accept,
    input  logic                                  i_clr_seen,
    input  logic                                  i_clr_err,
    input  logic                                  i_valid,
    input  logic [conv_sched_pkg::POOL_ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0]                     i_data,
    input  logic [OUT_AW-1:0]                     i_base,
    output logic                                  o_we,
    output logic [OUT_AW-1:0]                     o_waddr,
    output logic [DATA_W-1:0]                     o_wdata,
    output logic                                  o_all_seen,
    output logic                                  o_err_addr
);
    import conv_sched_pkg::*;

    logic                   r_we;
    logic [OUT_AW-1:0]      r_waddr;
    logic [DATA_W-1:0]      r_wdata;
    logic [OUT_PER_RUN-1:0] r_seen;
    logic                   r_err;
    logic                   w_in_range;
    logic                   w_hit;
    logic                   w_bad;
    logic [OUT_PER_RUN-1:0] w_dec;

    assign w_in_range = (i_addr <= POOL_ADDR_W'(OUT_PER_RUN - 1));
    assign w_hit      = i_accept && i_valid && w_in_range;
    assign w_bad      = i_accept && i_valid && !w_in_range;
    assign w_dec      = OUT_PER_RUN'(1) << i_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_hit;
            if (w_hit) begin
                r_waddr <= i_base + OUT_AW'(i_addr);
                r_wdata <= i_data;
            end
        end
    end

    // Duplicates rewrite memory but leave the mask as it was
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seen <= '0;
        end else if (i_clr_seen) begin
            r_seen <= '0;
        end else if (w_hit) begin
            r_seen <= r_seen | w_dec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (i_clr_err) begin
            r_err <= 1'b0;
        end else if (w_bad) begin
            r_err <= 1'b1;
        end
    end

    assign o_we       = r_we;
    assign o_waddr    = r_waddr;
    assign o_wdata    = r_wdata;
    assign o_all_seen = &r_seen;
    assign o_err_addr = r_err;

endmodule

// File: rtl/conv_run_scheduler.sv
// Sweeps filters x tiles through the conv processor, one run each.
// Optional run watchdog enabled by defining SCHED_WATCHDOG_EN.
module conv_run_scheduler #(
    parameter int NUM_FILTERS = 4,
    parameter int NUM_TILES   = 4,
    parameter int DATA_W      = 23,
    parameter int TIMEOUT_CYC = 1024,
    localparam int FW     = $clog2(NUM_FILTERS),
    localparam int TW     = $clog2(NUM_TILES),
    localparam int OUT_AW = $clog2(NUM_FILTERS * NUM_TILES * 9)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err_addr,
    output logic              err_timeout,
    output logic              proc_rst,
    output logic              proc_go,
    output logic [FW-1:0]     filter_sel,
    output logic [TW-1:0]     tile_sel,
    input  logic              res_valid,
    input  logic [3:0]        res_addr,
    input  logic [DATA_W-1:0] res_data,
    output logic              out_we,
    output logic [OUT_AW-1:0] out_waddr,
    output logic [DATA_W-1:0] out_wdata
);
    import conv_sched_pkg::*;

    state_t            r_state;
    state_t            w_next;
    logic [FW-1:0]     r_filter;
    logic [TW-1:0]     r_tile;
    logic [OUT_AW-1:0] r_base;
    logic              r_abort_done;
    logic              w_last;
    logic              w_start;
    logic              w_abort;
    logic              w_timeout;
    logic              w_all_seen;

    assign w_last  = (r_filter == FW'(NUM_FILTERS - 1)) &&
                     (r_tile == TW'(NUM_TILES - 1));
    assign w_start = (r_state == S_IDLE) && start;
    assign w_abort = (r_state != S_IDLE) && abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_abort_done <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_abort_done <= (w_abort || w_timeout) &&
                            !((r_state == S_NEXT) && w_last);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_PREP;
            S_PREP: w_next = S_GO;
            S_GO:   w_next = S_RUN;
            S_RUN:  if (w_all_seen) w_next = S_NEXT;
            S_NEXT: w_next = w_last ? S_IDLE : S_PREP;
            default: w_next = S_IDLE;
        endcase
        if (w_abort || w_timeout) w_next = S_IDLE;
    end

    always_comb begin
        busy     = 1'b0;
        done     = r_abort_done;
        proc_rst = 1'b1;
        proc_go  = 1'b0;
        case (r_state)
            S_PREP: busy = 1'b1;
            S_GO: begin
                busy     = 1'b1;
                proc_rst = 1'b0;
                proc_go  = 1'b1;
            end
            S_RUN: begin
                busy     = 1'b1;
                proc_rst = 1'b0;
            end
            S_NEXT: begin
                busy = !w_last;
                done = r_abort_done || w_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filter <= '0;
            r_tile   <= '0;
            r_base   <= '0;
        end else if (w_start) begin
            r_filter <= '0;
            r_tile   <= '0;
            r_base   <= '0;
        end else if (r_state == S_NEXT && !w_last && !w_abort) begin
            r_base <= r_base + OUT_AW'(OUT_PER_RUN);
            if (r_tile == TW'(NUM_TILES - 1)) begin
                r_tile   <= '0;
                r_filter <= r_filter + 1'b1;
            end else begin
                r_tile <= r_tile + 1'b1;
            end
        end
    end

`ifdef SCHED_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT_CYC);

    logic [WDW-1:0] r_wd;
    logic           r_err_timeout;
    logic           w_hit;

    assign w_hit = (r_state == S_RUN) && res_valid &&
                   (res_addr <= POOL_ADDR_W'(OUT_PER_RUN - 1));
    assign w_timeout = (r_state == S_RUN) && !w_all_seen && !w_hit &&
                       (r_wd == WDW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd          <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (r_state == S_GO || w_hit) begin
                r_wd <= '0;
            end else if (r_state == S_RUN) begin
                r_wd <= r_wd + 1'b1;
            end
            if (w_start) begin
                r_err_timeout <= 1'b0;
            end else if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign err_timeout = r_err_timeout;
`else
    assign w_timeout   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    run_result_tracker #(
        .DATA_W (DATA_W),
        .OUT_AW (OUT_AW)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .i_accept   (r_state == S_RUN),
        .i_clr_seen (r_state == S_PREP),
        .i_clr_err  (w_start),
        .i_valid    (res_valid),
        .i_addr     (res_addr),
        .i_data     (res_data),
        .i_base     (r_base),
        .o_we       (out_we),
        .o_waddr    (out_waddr),
        .o_wdata    (out_wdata),
        .o_all_seen (w_all_seen),
        .o_err_addr (err_addr)
    );

    assign filter_sel = r_filter;
    assign tile_sel   = r_tile;

endmodule

// File: tb/tb_conv_run_scheduler.sv
// Directed bench for conv_run_scheduler with a write scoreboard.
// Watchdog expectations follow SCHED_WATCHDOG_EN.
module tb_conv_run_scheduler;

    localparam int NF = 4;
    localparam int NT = 4;
    localparam int DW = 23;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          err_addr;
    logic          err_timeout;
    logic          proc_rst;
    logic          proc_go;
    logic [1:0]    filter_sel;
    logic [1:0]    tile_sel;
    logic          res_valid;
    logic [3:0]    res_addr;
    logic [DW-1:0] res_data;
    logic          out_we;
    logic [AW-1:0] out_waddr;
    logic [DW-1:0] out_wdata;

    conv_run_scheduler #(
        .NUM_FILTERS (NF),
        .NUM_TILES   (NT),
        .DATA_W      (DW),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .err_addr    (err_addr),
        .err_timeout (err_timeout),
        .proc_rst    (proc_rst),
        .proc_go     (proc_go),
        .filter_sel  (filter_sel),
        .tile_sel    (tile_sel),
        .res_valid   (res_valid),
        .res_addr    (res_addr),
        .res_data    (res_data),
        .out_we      (out_we),
        .out_waddr   (out_waddr),
        .out_wdata   (out_wdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t  sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_done = 0;
    int   n_go   = 0;
    logic prev_rst = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done) n_done++;
            if (proc_go) begin
                n_go++;
                chk("go_prev_rst", 32'(prev_rst), 32'd1);
            end
            if (out_we) begin
                if (sb.size() == 0) begin
                    chk("we_unexpected", 32'(out_waddr), 32'hFFFF);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    chk("waddr", 32'(out_waddr), 32'(e.a));
                    chk("wdata", 32'(out_wdata), 32'(e.d));
                end
            end
        end
        prev_rst = proc_rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int a, input logic [DW-1:0] d,
                          input int base, input bit push);
        res_valid = 1'b1;
        res_addr  = 4'(a);
        res_data  = d;
        if (push) sb.push_back({AW'(base + a), d});
        tick();
        res_valid = 1'b0;
    endtask

    task automatic wait_go(input string tag, output int k);
        k = 0;
        while (!proc_go && k < 20) begin
            tick();
            k++;
        end
        chk(tag, 32'(proc_go), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_normal(input int r, input int base, input bit last);
        int k;
        wait_go("run_go", k);
        chk("filter_sel", 32'(filter_sel), 32'(r / NT));
        chk("tile_sel", 32'(tile_sel), 32'(r % NT));
        tick();
        for (int a = 0; a < 9; a++) strobe(a, DW'($urandom), base, 1'b1);
        tick();
        if (last) begin
            chk("last_done", 32'(done), 32'd1);
            chk("last_busy", 32'(busy), 32'd0);
        end else begin
            chk("next_prst", 32'(proc_rst), 32'd1);
            chk("next_busy", 32'(busy), 32'd1);
        end
    endtask

    initial begin
        int k;
        int seq[9];
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        res_valid = 1'b0;
        res_addr  = '0;
        res_data  = '0;
        tick();
        tick();
        chk("rst_prst", 32'(proc_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_go", 32'(proc_go), 32'd0);
        chk("rst_we", 32'(out_we), 32'd0);
        chk("rst_err", 32'({err_addr, err_timeout}), 32'd0);
        rst = 1'b0;
        tick();

        // full sweep, in-order results
        pulse_start();
        chk("prep_busy", 32'(busy), 32'd1);
        chk("prep_prst", 32'(proc_rst), 32'd1);
        chk("prep_go", 32'(proc_go), 32'd0);
        tick();
        chk("go_latency", 32'(proc_go), 32'd1);
        for (int r = 0; r < NF * NT; r++) run_normal(r, r * 9, r == NF * NT - 1);
        tick();
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("sweep_sb", 32'(sb.size()), 32'd0);
        chk("sweep_ndone", 32'(n_done), 32'd1);
        chk("sweep_go", 32'(n_go), 32'd16);

        // out-of-order with a duplicate
        pulse_start();
        wait_go("ooo_go", k);
        tick();
        seq = '{8, 3, 3, 0, 1, 2, 4, 5, 6};
        foreach (seq[i]) strobe(seq[i], DW'(100 + seq[i]), 0, 1'b1);
        tick();
        tick();
        chk("ooo_still_run", 32'(proc_rst), 32'd0);
        strobe(7, DW'(107), 0, 1'b1);
        tick();
        chk("ooo_next", 32'(proc_rst), 32'd1);
        chk("ooo_err", 32'(err_addr), 32'd0);

        // bad address mid-run
        wait_go("bad_go", k);
        tick();
        for (int a = 0; a < 4; a++) strobe(a, DW'($urandom), 9, 1'b1);
        strobe(12, DW'(555), 9, 1'b0);
        chk("bad_no_we", 32'(out_we), 32'd0);
        chk("bad_err", 32'(err_addr), 32'd1);
        for (int a = 4; a < 9; a++) strobe(a, DW'($urandom), 9, 1'b1);
        tick();
        chk("bad_next", 32'(proc_rst), 32'd1);
        for (int r = 2; r < 5; r++) run_normal(r, r * 9, 1'b0);
        chk("err_sticky", 32'(err_addr), 32'd1);

        // abort in run 5 after four results
        wait_go("abort_go", k);
        chk("abort_tile", 32'(tile_sel), 32'd1);
        tick();
        for (int a = 0; a < 4; a++) strobe(a, DW'($urandom), 45, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done", 32'(done), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_prst", 32'(proc_rst), 32'd1);
        repeat (5) tick();
        chk("abort_done_low", 32'(done), 32'd0);
        chk("abort_sb", 32'(sb.size()), 32'd0);
        chk("abort_err_end", 32'(err_addr), 32'd1);
        chk("abort_ndone", 32'(n_done), 32'd2);

        // restart from address 0, then async reset mid-run
        pulse_start();
        chk("restart_err_clr", 32'(err_addr), 32'd0);
        run_normal(0, 0, 1'b0);
        wait_go("rst_run_go", k);
        tick();
        for (int a = 0; a < 3; a++) strobe(a, DW'($urandom), 9, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_prst", 32'(proc_rst), 32'd1);
        chk("arst_we", 32'(out_we), 32'd0);
        chk("arst_sel", 32'({filter_sel, tile_sel}), 32'd0);
        chk("arst_pending", 32'(sb.size()), 32'd1);
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("arst_ndone", 32'(n_done), 32'd2);

        // restart, then stall the model after five results
        pulse_start();
        run_normal(0, 0, 1'b0);
        run_normal(1, 9, 1'b0);
        wait_go("wd_go", k);
        tick();
        for (int a = 0; a < 5; a++) strobe(a, DW'($urandom), 18, 1'b1);
`ifdef SCHED_WATCHDOG_EN
        k = 0;
        while (!done && k < 40) begin
            tick();
            k++;
        end
        chk("wd_done", 32'(done), 32'd1);
        chk("wd_cycles", 32'(k), 32'd16);
        chk("wd_err", 32'(err_timeout), 32'd1);
        chk("wd_busy", 32'(busy), 32'd0);
`else
        repeat (40) tick();
        chk("nowd_busy", 32'(busy), 32'd1);
        chk("nowd_err", 32'(err_timeout), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("nowd_abort_done", 32'(done), 32'd1);
`endif
        tick();
        tick();
        chk("end_ndone", 32'(n_done), 32'd3);
        chk("end_ngo", 32'(n_go), 32'd27);
        chk("end_sb", 32'(sb.size()), 32'd0);
        chk("end_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
